// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte-lane stores, sign/zero-extended loads,
// req/ack SRAM handshake with timeout, UART MMIO decode and write-back mux.
module mem_access_unit #(
  parameter int          BUS_AW         = 30,
  parameter logic [31:0] UART_DATA_ADDR = 32'hBFD003F8,
  parameter logic [31:0] UART_STAT_ADDR = 32'hBFD003FC,
  parameter int          TIMEOUT        = 255,
  parameter int          TMO_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              lui_sig,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       din,
  input  logic [15:0]       imme,
  output logic [31:0]       dout,
  output logic              stall,
  output logic              addr_err,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [BUS_AW-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack,
  output logic [7:0]        uart_wdata,
  output logic              uart_write_ce,
  input  logic [7:0]        uart_rdata,
  output logic              clean_recv_flag,
  input  logic              recv_flag,
  input  logic              send_flag
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, UART_TX} state_t;

  state_t              state_q, state_d;
  logic [BUS_AW-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          lo_q, lo_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         data_q, data_d;
  logic                tmo_q, tmo_d;
  logic [7:0]          tx_q, tx_d;

  logic                op, is_wr, is_half, is_word, misaligned, hit_data, hit_stat;
  logic [31:0]         ld_data;

  // Lane-select a load and extend it to 32 bits.
  function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [1:0] lo,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] lane;
    lane = rd >> {lo, 3'b000};
    case (sz)
      2'b00:   fmt_load = uns ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   fmt_load = uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: fmt_load = lane;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   byte_en = 4'b0001 << lo;
      2'b01:   byte_en = 4'b0011 << {lo[1], 1'b0};
      default: byte_en = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   lane_wdata = {4{d[7:0]}};
      2'b01:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  assign op         = req_valid & (mem_read | mem_write);
  assign is_wr      = mem_write;
  assign is_half    = (mem_size == 2'b01);
  assign is_word    = mem_size[1];
  assign misaligned = (is_half & alu_result[0]) | (is_word & (alu_result[1:0] != 2'b00));
  // MMIO decode ignores the top segment bits so kseg/useg aliases hit the same register.
  assign hit_data   = (alu_result[28:2] == UART_DATA_ADDR[28:2]);
  assign hit_stat   = (alu_result[28:2] == UART_STAT_ADDR[28:2]);

  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;
  assign bus_we     = we_q & (state_q == WAIT);

  // State and captured-transaction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      lo_q    <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      tmo_q   <= 1'b0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state, handshake, MMIO strobes and write-back mux; all outputs held at 0 while in reset.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    be_d            = be_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    lo_d            = lo_q;
    size_d          = size_q;
    uns_d           = uns_q;
    cnt_d           = cnt_q;
    data_d          = data_q;
    tmo_d           = tmo_q;
    tx_d            = tx_q;
    stall           = 1'b0;
    addr_err        = 1'b0;
    bus_err         = 1'b0;
    bus_req         = 1'b0;
    uart_write_ce   = 1'b0;
    uart_wdata      = 8'h0;
    clean_recv_flag = 1'b0;
    ld_data         = 32'h0;
    dout            = 32'h0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (op) begin
            if (misaligned) begin
              addr_err = 1'b1;
            end else if (hit_data && is_wr) begin
              if (send_flag) begin
                uart_write_ce = 1'b1;
                uart_wdata    = din[7:0];
              end else begin
                stall   = 1'b1;
                tx_d    = din[7:0];
                state_d = UART_TX;
              end
            end else if (hit_data) begin
              ld_data         = {24'h0, uart_rdata};
              clean_recv_flag = 1'b1;
            end else if (hit_stat) begin
              if (!is_wr) ld_data = {30'h0, recv_flag, send_flag};
            end else begin
              stall   = 1'b1;
              addr_d  = BUS_AW'(alu_result[28:2]);
              be_d    = byte_en(mem_size, alu_result[1:0]);
              we_d    = is_wr;
              wdata_d = is_wr ? lane_wdata(mem_size, din) : 32'h0;
              lo_d    = alu_result[1:0];
              size_d  = mem_size;
              uns_d   = mem_unsigned;
              cnt_d   = '0;
              tmo_d   = 1'b0;
              data_d  = 32'h0;
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          bus_req = 1'b1;
          stall   = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (bus_ack) begin
            data_d  = we_q ? 32'h0 : fmt_load(bus_rdata, lo_q, size_q, uns_q);
            state_d = DONE;
          end else if (cnt_q == TMO_W'(TIMEOUT - 1)) begin
            tmo_d   = 1'b1;
            data_d  = 32'h0;
            state_d = DONE;
          end
        end
        DONE: begin
          bus_err = tmo_q;
          ld_data = data_q;
          tmo_d   = 1'b0;
          state_d = IDLE;
        end
        UART_TX: begin
          stall = 1'b1;
          if (send_flag) begin
            stall         = 1'b0;
            uart_write_ce = 1'b1;
            uart_wdata    = tx_q;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (lui_sig)         dout = {imme, 16'h0};
      else if (mem_to_reg) dout = ld_data;
      else                 dout = alu_result;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: single-cycle IDLE vectors from a table,
// plus hand-written multi-cycle sequences (bus loads/stores, timeout, UART TX stall, reset).
module tb_mem_access_unit;

  logic        clk, rst;
  logic        req_valid, mem_read, mem_write, mem_to_reg, lui_sig, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] alu_result, din, dout, bus_wdata, bus_rdata;
  logic [15:0] imme;
  logic        stall, addr_err, bus_err, bus_req, bus_we, bus_ack;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [7:0]  uart_wdata, uart_rdata;
  logic        uart_write_ce, clean_recv_flag, recv_flag, send_flag;

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_access_unit #(.BUS_AW(30), .TIMEOUT(4), .TMO_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .lui_sig(lui_sig), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .alu_result(alu_result), .din(din), .imme(imme), .dout(dout), .stall(stall),
    .addr_err(addr_err), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .uart_wdata(uart_wdata), .uart_write_ce(uart_write_ce),
    .uart_rdata(uart_rdata), .clean_recv_flag(clean_recv_flag), .recv_flag(recv_flag),
    .send_flag(send_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic        valid, rd, wr, m2r, lui;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] alu, dat;
    logic [15:0] imm;
    logic        snd, rcv;
    logic [7:0]  urd;
    logic [31:0] e_dout;
    logic        e_stall, e_aerr, e_wce;
    logic [7:0]  e_wdat;
    logic        e_crf;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; lui_sig = 0;
    mem_size = 2'b00; mem_unsigned = 0; alu_result = 0; din = 0; imme = 0;
    bus_rdata = 0; bus_ack = 0; uart_rdata = 0; recv_flag = 0; send_flag = 1;
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic m2r, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1; mem_read = rd; mem_write = wr; mem_to_reg = m2r; lui_sig = 0;
    mem_size = sz; mem_unsigned = uns; alu_result = a; din = d;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_dout"}, dout, 32'h0);
    chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
    chk({tag, "_bus_req"}, {31'h0, bus_req}, 32'h0);
    chk({tag, "_bus_we"}, {31'h0, bus_we}, 32'h0);
    chk({tag, "_bus_addr"}, {2'b00, bus_addr}, 32'h0);
    chk({tag, "_bus_be"}, {28'h0, bus_be}, 32'h0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'h0);
    chk({tag, "_errs"}, {30'h0, addr_err, bus_err}, 32'h0);
    chk({tag, "_uart"}, {22'h0, uart_write_ce, clean_recv_flag, uart_wdata}, 32'h0);
  endtask

  // Bus load with ack in the first WAIT cycle; returns the write-back value seen in DONE.
  task automatic bus_load(input string tag, input logic uns, input logic [31:0] exp_dout);
    drive_op(1, 0, 1, 2'b00, uns, 32'h80000003, 32'h0);
    @(negedge clk);
    chk({tag, "_c0_stall"}, {31'h0, stall}, 32'h1);
    chk({tag, "_c0_req"}, {31'h0, bus_req}, 32'h0);
    tick();
    bus_rdata = 32'h80FF0000; bus_ack = 1;
    @(negedge clk);
    chk({tag, "_c1_stall"}, {31'h0, stall}, 32'h1);
    chk({tag, "_c1_req"}, {31'h0, bus_req}, 32'h1);
    chk({tag, "_be"}, {28'h0, bus_be}, 32'h8);
    chk({tag, "_addr"}, {2'b00, bus_addr}, 32'h0);
    chk({tag, "_we"}, {31'h0, bus_we}, 32'h0);
    tick();
    bus_ack = 0; bus_rdata = 32'h0;
    @(negedge clk);
    chk({tag, "_done_stall"}, {31'h0, stall}, 32'h0);
    chk({tag, "_done_req"}, {31'h0, bus_req}, 32'h0);
    chk({tag, "_dout"}, dout, exp_dout);
    tick();
    idle_inputs();
  endtask

  initial begin
    int nreq, nst, k;
    logic early, wce_seen;

    vt[0]  = '{0,0,0,0,0,2'b10,0,32'h12345678,32'h0,16'h0,1,0,8'h0, 32'h12345678,0,0,0,8'h0,0};
    vt[1]  = '{0,0,0,0,1,2'b10,0,32'h12345678,32'h0,16'hABCD,1,0,8'h0, 32'hABCD0000,0,0,0,8'h0,0};
    vt[2]  = '{1,1,0,1,0,2'b10,0,32'h80000006,32'h0,16'h0,1,0,8'h0, 32'h0,0,1,0,8'h0,0};
    vt[3]  = '{1,1,0,1,0,2'b01,0,32'h80000001,32'h0,16'h0,1,0,8'h0, 32'h0,0,1,0,8'h0,0};
    vt[4]  = '{1,0,1,0,0,2'b10,0,32'h80000002,32'hDEADBEEF,16'h0,1,0,8'h0, 32'h80000002,0,1,0,8'h0,0};
    vt[5]  = '{1,1,0,1,0,2'b00,1,32'hBFD003F8,32'h0,16'h0,1,0,8'hA5, 32'h000000A5,0,0,0,8'h0,1};
    vt[6]  = '{1,1,0,1,0,2'b10,0,32'hBFD003FC,32'h0,16'h0,0,1,8'hA5, 32'h00000002,0,0,0,8'h0,0};
    vt[7]  = '{1,0,1,0,0,2'b00,0,32'hBFD003F8,32'h11223344,16'h0,1,0,8'h0, 32'hBFD003F8,0,0,1,8'h44,0};
    vt[8]  = '{1,1,0,1,0,2'b00,0,32'h1FD003F8,32'h0,16'h0,1,0,8'h3C, 32'h0000003C,0,0,0,8'h0,1};
    vt[9]  = '{1,1,1,0,0,2'b00,0,32'hBFD003F8,32'hCAFE0055,16'h0,1,0,8'h77, 32'hBFD003F8,0,0,1,8'h55,0};
    vt[10] = '{1,1,0,1,1,2'b01,0,32'h00000003,32'h0,16'h0F0F,1,0,8'h0, 32'h0F0F0000,0,1,0,8'h0,0};

    // Reset state
    idle_inputs();
    rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1;
    tick();

    // Single-cycle IDLE vectors
    for (int i = 0; i < 11; i++) begin
      req_valid = vt[i].valid; mem_read = vt[i].rd; mem_write = vt[i].wr;
      mem_to_reg = vt[i].m2r; lui_sig = vt[i].lui; mem_size = vt[i].sz;
      mem_unsigned = vt[i].uns; alu_result = vt[i].alu; din = vt[i].dat; imme = vt[i].imm;
      send_flag = vt[i].snd; recv_flag = vt[i].rcv; uart_rdata = vt[i].urd;
      @(negedge clk);
      chk($sformatf("vec%0d_dout", i), dout, vt[i].e_dout);
      chk($sformatf("vec%0d_stall", i), {31'h0, stall}, {31'h0, vt[i].e_stall});
      chk($sformatf("vec%0d_addr_err", i), {31'h0, addr_err}, {31'h0, vt[i].e_aerr});
      chk($sformatf("vec%0d_wce", i), {31'h0, uart_write_ce}, {31'h0, vt[i].e_wce});
      chk($sformatf("vec%0d_uart_wdata", i), {24'h0, uart_wdata}, {24'h0, vt[i].e_wdat});
      chk($sformatf("vec%0d_crf", i), {31'h0, clean_recv_flag}, {31'h0, vt[i].e_crf});
      chk($sformatf("vec%0d_bus_req", i), {31'h0, bus_req}, 32'h0);
      tick();
      idle_inputs();
    end
    // Misaligned op must not have started a bus cycle on the following edge
    @(negedge clk);
    chk("post_vec_bus_req", {31'h0, bus_req}, 32'h0);
    tick();

    // lb / lbu from the top byte lane
    bus_load("lb", 1'b0, 32'hFFFFFF80);
    bus_load("lbu", 1'b1, 32'h00000080);

    // sh into the upper half-word
    drive_op(0, 1, 0, 2'b01, 0, 32'h80000002, 32'h1234ABCD);
    @(negedge clk);
    chk("sh_c0_stall", {31'h0, stall}, 32'h1);
    tick();
    bus_ack = 1;
    @(negedge clk);
    chk("sh_req", {31'h0, bus_req}, 32'h1);
    chk("sh_be", {28'h0, bus_be}, 32'hC);
    chk("sh_wdata", bus_wdata, 32'hABCDABCD);
    chk("sh_we", {31'h0, bus_we}, 32'h1);
    tick();
    bus_ack = 0;
    @(negedge clk);
    chk("sh_done_stall", {31'h0, stall}, 32'h0);
    chk("sh_done_dout", dout, 32'h80000002);
    tick();
    idle_inputs();

    // Timeout with no ack
    drive_op(1, 0, 1, 2'b10, 0, 32'h00000010, 32'h0);
    @(negedge clk);
    chk("tmo_c0_stall", {31'h0, stall}, 32'h1);
    nreq = 0; early = 0;
    for (k = 0; k < 20; k++) begin
      tick();
      @(negedge clk);
      if (!bus_req) break;
      nreq++;
      if (bus_err) early = 1'b1;
      if (nreq == 1) chk("tmo_addr", {2'b00, bus_addr}, 32'h4);
    end
    chk("tmo_bounded", (k < 20) ? 32'h1 : 32'h0, 32'h1);
    chk("tmo_req_cycles", nreq, 32'd4);
    chk("tmo_err_early", {31'h0, early}, 32'h0);
    chk("tmo_bus_err", {31'h0, bus_err}, 32'h1);
    chk("tmo_dout", dout, 32'h0);
    chk("tmo_stall", {31'h0, stall}, 32'h0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("tmo_err_once", {31'h0, bus_err}, 32'h0);
    tick();

    // UART TX stalls while the transmitter is busy
    drive_op(0, 1, 0, 2'b00, 0, 32'hBFD003F8, 32'h000000E7);
    nst = 0; wce_seen = 0;
    for (int c = 0; c < 12; c++) begin
      send_flag = (c >= 3);
      @(negedge clk);
      if (stall) begin
        nst++;
        if (uart_write_ce) wce_seen = 1'b1;
      end
      if (uart_write_ce) begin
        chk("tx_wdata", {24'h0, uart_wdata}, 32'hE7);
        chk("tx_stall_at_pulse", {31'h0, stall}, 32'h0);
        break;
      end
      tick();
      if (c == 11) chk("tx_bounded", 32'h0, 32'h1);
    end
    chk("tx_stall_cycles", nst, 32'd3);
    chk("tx_wce_during_stall", {31'h0, wce_seen}, 32'h0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("tx_wce_once", {31'h0, uart_write_ce}, 32'h0);
    tick();

    // Reset in the middle of a bus wait
    drive_op(1, 0, 1, 2'b10, 0, 32'h00000100, 32'h0);
    tick();
    @(negedge clk);
    chk("rstw_req_before", {31'h0, bus_req}, 32'h1);
    #1 rst = 0;
    #1;
    chk("rstw_req_drop", {31'h0, bus_req}, 32'h0);
    chk("rstw_stall_drop", {31'h0, stall}, 32'h0);
    tick();
    idle_inputs();
    @(negedge clk);
    rst = 1;
    tick();
    @(negedge clk);
    check_zero_outputs("rstw_after");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
